// File: rtl/kitchen_timer_ctrl.sv
// kitchen_timer_ctrl: mm:ss countdown sequencer (load, 1 Hz BCD decrement, start/pause/clear), BCD display outputs.
// Optional DONE auto-clear after ALARM_SECS seconds when KITCHEN_TIMER_ALARM_TIMEOUT_EN is defined.
module kitchen_timer_ctrl #(
  parameter int CLK_HZ     = 100000000,
  parameter int ALARM_SECS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] in,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  output logic [7:0]  min_bcd,
  output logic [7:0]  sec_bcd,
  output logic        running,
  output logic        paused,
  output logic        timeUp,
  output logic        tick
);
  localparam int PW = $clog2(CLK_HZ);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t        state_q;
  logic [PW-1:0] pre_q;
  logic [15:0]   cnt_q;
  logic          running_q, paused_q, time_up_q, tick_q;
  logic [6:0]    min_clamp;
  logic [5:0]    sec_clamp;
  logic [15:0]   load_d, dec_d;
  logic          load_ok, pre_last, dec_zero;
  logic          s0_borrow, s1_borrow, m0_borrow;
`ifdef KITCHEN_TIMER_ALARM_TIMEOUT_EN
  localparam int AW = $clog2(ALARM_SECS + 1);
  logic [AW-1:0] alarm_q;
`else
  logic unused_alarm;
  assign unused_alarm = ALARM_SECS != 0;
`endif

  // Clamp the preset switches to 99:59 and convert to BCD for loading
  always_comb begin
    min_clamp = (in[12:6] > 7'd99) ? 7'd99 : in[12:6];
    sec_clamp = (in[5:0] > 6'd59) ? 6'd59 : in[5:0];
    load_d    = {4'(min_clamp / 7'd10), 4'(min_clamp % 7'd10), 4'(sec_clamp / 6'd10), 4'(sec_clamp % 6'd10)};
    load_ok   = (min_clamp != 7'd0) || (sec_clamp != 6'd0);
  end

  // One-second BCD decrement, borrow rippling seconds ones -> tens -> minutes
  always_comb begin
    s0_borrow    = cnt_q[3:0] == 4'd0;
    s1_borrow    = s0_borrow && (cnt_q[7:4] == 4'd0);
    m0_borrow    = s1_borrow && (cnt_q[11:8] == 4'd0);
    dec_d[3:0]   = s0_borrow ? 4'd9 : cnt_q[3:0] - 4'd1;
    dec_d[7:4]   = s0_borrow ? ((cnt_q[7:4] == 4'd0) ? 4'd5 : cnt_q[7:4] - 4'd1) : cnt_q[7:4];
    dec_d[11:8]  = s1_borrow ? ((cnt_q[11:8] == 4'd0) ? 4'd9 : cnt_q[11:8] - 4'd1) : cnt_q[11:8];
    dec_d[15:12] = m0_borrow ? ((cnt_q[15:12] == 4'd0) ? 4'd9 : cnt_q[15:12] - 4'd1) : cnt_q[15:12];
    dec_zero     = dec_d == 16'd0;
    pre_last     = pre_q == PW'(CLK_HZ - 1);
  end

  // Controller FSM: state, count, prescaler and all status outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      time_up_q <= 1'b0;
      tick_q    <= 1'b0;
`ifdef KITCHEN_TIMER_ALARM_TIMEOUT_EN
      alarm_q   <= '0;
`endif
    end else begin
      tick_q <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
        pre_q   <= '0;
        cnt_q   <= '0;
        {running_q, paused_q, time_up_q} <= 3'b000;
`ifdef KITCHEN_TIMER_ALARM_TIMEOUT_EN
        alarm_q <= '0;
`endif
      end else begin
        case (state_q)
          RUN: begin
            pre_q <= pre_last ? '0 : pre_q + 1'b1;
            if (pre_last) begin
              cnt_q  <= dec_d;
              tick_q <= 1'b1;
            end
            if (pre_last && dec_zero) begin
              state_q <= DONE;
              {running_q, paused_q, time_up_q} <= 3'b001;
`ifdef KITCHEN_TIMER_ALARM_TIMEOUT_EN
              alarm_q <= '0;
`endif
            end else if (pause) begin
              state_q <= PAUSE;
              {running_q, paused_q, time_up_q} <= 3'b010;
            end
          end
          PAUSE: begin
            if (pause || start) begin
              state_q <= RUN;
              {running_q, paused_q, time_up_q} <= 3'b100;
            end
          end
          IDLE, DONE: begin
            if (start && load_ok) begin
              state_q <= RUN;
              pre_q   <= '0;
              cnt_q   <= load_d;
              {running_q, paused_q, time_up_q} <= 3'b100;
            end
`ifdef KITCHEN_TIMER_ALARM_TIMEOUT_EN
            else if (state_q == DONE) begin
              pre_q <= pre_last ? '0 : pre_q + 1'b1;
              if (pre_last) alarm_q <= alarm_q + 1'b1;
              if (pre_last && alarm_q == AW'(ALARM_SECS - 1)) begin
                state_q <= IDLE;
                alarm_q <= '0;
                {running_q, paused_q, time_up_q} <= 3'b000;
              end
            end
`endif
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign min_bcd = cnt_q[15:8];
  assign sec_bcd = cnt_q[7:0];
  assign running = running_q;
  assign paused  = paused_q;
  assign timeUp  = time_up_q;
  assign tick    = tick_q;
endmodule

// File: tb/tb_kitchen_timer_ctrl.sv
// tb_kitchen_timer_ctrl: directed + randomized bench against a seconds-level behavioural model.
module tb_kitchen_timer_ctrl;
  localparam int CLK_HZ = 10;
  localparam int ALARM_SECS = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [12:0] in = '0;
  logic start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [7:0] min_bcd, sec_bcd;
  logic running, paused, timeUp, tick;
  int checks = 0, errors = 0;
  int m_st, m_rem, m_phase, m_done_cyc;
  bit m_tick;
  int rc, n;

  always #5 clk = ~clk;

  kitchen_timer_ctrl #(.CLK_HZ(CLK_HZ), .ALARM_SECS(ALARM_SECS)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .start(start), .pause(pause), .clear(clear),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running), .paused(paused),
    .timeUp(timeUp), .tick(tick)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int preset_secs(input logic [12:0] v);
    int mm = (v[12:6] > 7'd99) ? 99 : int'(v[12:6]);
    int ss = (v[5:0] > 6'd59) ? 59 : int'(v[5:0]);
    return mm * 60 + ss;
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) + v % 10);
  endfunction

  task automatic model_reset();
    m_st = 0; m_rem = 0; m_phase = 0; m_done_cyc = 0; m_tick = 0;
  endtask

  // model: 0 idle, 1 run, 2 pause, 3 done; m_rem = remaining seconds
  task automatic model_step();
    m_tick = 0;
    if (clear) model_reset();
    else if ((m_st == 0 || m_st == 3) && start && preset_secs(in) > 0) begin
      m_rem = preset_secs(in); m_phase = 0; m_st = 1;
    end else if (m_st == 1) begin
      m_phase++;
      if (m_phase == CLK_HZ) begin m_phase = 0; m_rem--; m_tick = 1; end
      if (m_tick && m_rem == 0) begin m_st = 3; m_done_cyc = 0; end
      else if (pause) m_st = 2;
    end else if (m_st == 2) begin
      if (pause || start) m_st = 1;
    end else if (m_st == 3) begin
`ifdef KITCHEN_TIMER_ALARM_TIMEOUT_EN
      m_done_cyc++;
      if (m_done_cyc == ALARM_SECS * CLK_HZ) m_st = 0;
`endif
    end
  endtask

  task automatic compare_all();
    check("min", min_bcd, bcd(m_rem / 60));
    check("sec", sec_bcd, bcd(m_rem % 60));
    check("running", running, m_st == 1);
    check("paused", paused, m_st == 2);
    check("timeUp", timeUp, m_st == 3);
    check("tick", tick, m_tick);
  endtask

  task automatic cyc(input logic s, input logic p, input logic c);
    start = s; pause = p; clear = c;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    start = 0; pause = 0; clear = 0;
  endtask

  initial begin
    model_reset();
    #12;
    compare_all();
    @(negedge clk) rst_n = 1'b1;
    // 00:03 countdown
    in = {7'd0, 6'd3};
    cyc(1, 0, 0);
    check("t3_load", {min_bcd, sec_bcd}, 16'h0003);
    check("t3_run", running, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      cyc(0, 0, 0);
      if (k % 10 == 0) begin
        check("t3_tick", tick, 1'b1);
        check("t3_disp", {min_bcd, sec_bcd}, 16'(3 - k / 10));
      end
    end
    check("t3_timeup", timeUp, 1'b1);
    // borrows
    cyc(0, 0, 1);
    in = {7'd2, 6'd0};
    cyc(1, 0, 0);
    repeat (10) cyc(0, 0, 0);
    check("borrow_2m", {min_bcd, sec_bcd}, 16'h0159);
    cyc(0, 0, 1);
    in = {7'd10, 6'd0};
    cyc(1, 0, 0);
    repeat (10) cyc(0, 0, 0);
    check("borrow_10m", {min_bcd, sec_bcd}, 16'h0959);
    // clamp, start ignored in RUN, zero preset
    cyc(0, 0, 1);
    in = {7'd120, 6'd63};
    cyc(1, 0, 0);
    check("clamp", {min_bcd, sec_bcd}, 16'h9959);
    in = 13'd5;
    cyc(1, 0, 0);
    check("start_in_run", {min_bcd, sec_bcd}, 16'h9959);
    cyc(0, 0, 1);
    in = '0;
    cyc(1, 0, 0);
    check("zero_running", running, 1'b0);
    // pause accounting
    in = {7'd0, 6'd5};
    cyc(1, 0, 0);
    rc = int'(running);
    repeat (14) begin cyc(0, 0, 0); rc += int'(running); end
    cyc(0, 1, 0);
    check("pause_enter", paused, 1'b1);
    repeat (37) cyc(0, 0, 0);
    check("pause_hold", {min_bcd, sec_bcd}, 16'h0004);
    cyc(0, 1, 0);
    check("pause_resume", running, 1'b1);
    rc += int'(running);
    n = 0;
    while (!timeUp && n < 200) begin cyc(0, 0, 0); rc += int'(running); n++; end
    check("pause_done", timeUp, 1'b1);
    check("run_cycles", 16'(rc), 16'd50);
    // clear beats start
    in = {7'd0, 6'd9};
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    cyc(1, 0, 1);
    check("clear_start", {7'd0, running, min_bcd, sec_bcd}, 16'h0000);
    // asynchronous reset between edges
    cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk) rst_n = 1'b1;
    // DONE behaviour
    in = {7'd0, 6'd1};
    cyc(1, 0, 0);
    n = 0;
    while (!timeUp && n < 30) begin cyc(0, 0, 0); n++; end
    check("done_reach", timeUp, 1'b1);
`ifdef KITCHEN_TIMER_ALARM_TIMEOUT_EN
    n = 0;
    while (timeUp && n < 100) begin cyc(0, 0, 0); n++; end
    check("alarm_cycles", 16'(n), 16'd20);
`else
    repeat (200) cyc(0, 0, 0);
    check("done_hold", timeUp, 1'b1);
    cyc(1, 0, 0);
    check("done_reload", {min_bcd, sec_bcd}, 16'h0001);
    check("done_reload_run", running, 1'b1);
`endif
    // randomized traffic
    repeat (2000) begin
      if ($urandom_range(0, 19) == 0)
        in = {($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 1)), 6'($urandom_range(0, 63))};
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/kitchen_timer_ctrl.md
# kitchen_timer_ctrl

Sequencing controller for the kitchen timer: it loads a mm:ss preset from the 13 panel switches, counts it down once per second, and handles start, pause/resume and clear commands. It raises `timeUp` when the count reaches 00:00. It sits between the debounced panel inputs and the seven-segment display driver. It owns the countdown state and exposes the count as four BCD digits for the display mux.

## Interface
- `CLK_HZ`, default 100000000: clock frequency; one-second prescaler divides by `CLK_HZ`; must be ≥ 2.
- `ALARM_SECS`, default 10: seconds `timeUp` stays high before auto-clear; used only with the macro enabled.

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in`  in  13  preset: `in[12:6]` minutes (binary), `in[5:0]` seconds (binary)
- `start`  in  1  single-cycle pulse, synchronous, debounced upstream
- `pause`  in  1  single-cycle pulse; toggles run/pause
- `clear`  in  1  single-cycle pulse; abort to idle
- `min_bcd`  out  8  minutes, two BCD digits {tens, ones}
- `sec_bcd`  out  8  seconds, two BCD digits {tens, ones}
- `running`  out  1  high in RUN
- `paused`  out  1  high in PAUSE
- `timeUp`  out  1  high in DONE
- `tick`  out  1  one-cycle pulse coincident with each new decremented value

## Operation
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Reset: IDLE, count 00:00, prescaler 0. All outputs are 0.
- Command priority when pulses coincide: `clear` > `start` > `pause`.
- `clear` in any state: go to IDLE, count 00:00, prescaler 0.
- Load rule: minutes = min(`in[12:6]`, 99); seconds = min(`in[5:0]`, 59). The clamped values are converted to BCD on load.
- IDLE + `start`:
  - Clamped preset ≠ 00:00: load preset, prescaler 0, go to RUN.
  - Clamped preset = 00:00: ignore the command and stay in IDLE.
- IDLE ignores `pause`.
- RUN:
  - The prescaler counts 0..`CLK_HZ`-1.
  - At terminal count it wraps to 0 and the count decrements by one second in BCD:
    - seconds ones 0 → 9 with borrow;
    - seconds tens 0 → 5 with borrow into minutes;
    - minutes digits borrow 0 → 9.
  - If the decrement yields 00:00, go to DONE on the same edge.
- RUN + `pause`: go to PAUSE. RUN + `start`: ignored.
- PAUSE: prescaler and count hold. `pause` or `start` resumes RUN without resetting the prescaler.
- DONE: count holds at 00:00 and `timeUp` = 1.
  - `start` reloads the preset and goes to RUN, with the same zero-preset rule as IDLE: a zero preset stays in DONE.
  - `pause` is ignored.
- `in` is sampled only on a load edge. Switch changes during RUN, PAUSE or DONE have no effect.
- Reset asserted mid-count forces IDLE and 00:00 immediately, with no clock required.

## Timing
- `start` sampled at edge N: at N+0 (registered) the state is RUN, the display equals the preset and the prescaler is 0.
- The first decrement occurs at edge N+`CLK_HZ`. Subsequent decrements occur every `CLK_HZ` cycles spent in RUN.
- `tick` is high for exactly the one cycle following each decrement edge, including the final decrement to 00:00.
- `timeUp` rises on the same edge the count becomes 00:00. `running` falls on that same edge.
- Pause latency is one edge. Cycles spent in PAUSE do not advance the prescaler, so total RUN cycles to 00:00 = preset_seconds × `CLK_HZ`.
- `clear` takes effect on the sampling edge. No output glitches, because all outputs are registered.

## Configuration
- `KITCHEN_TIMER_ALARM_TIMEOUT_EN` defined:
  - DONE auto-returns to IDLE after `ALARM_SECS` × `CLK_HZ` cycles, using the prescaler plus a seconds counter.
  - `timeUp` then falls and the count stays 00:00.
  - `clear` or `start` still act earlier.
- Undefined: DONE persists until `clear`, `start` or reset. The `ALARM_SECS` parameter is unused.

## Test plan
(Bench uses `CLK_HZ`=10.)
- Preset `in`={7'd0, 6'd3}, `start` → display 00:03, `running`=1; `tick` at +10, +20 and +30 cycles with display 00:02, 00:01, 00:00; `timeUp`=1 at +30 cycles.
- Preset 2:00 → after the first tick, display 01:59 (borrow across both second digits and into minutes); preset 10:00 → 09:59.
- Clamping: `in`={7'd120, 6'd63} + `start` → display 99:59. Zero preset + `start` → stays IDLE, `running`=0.
- Pause: start 00:05, `pause` at cycle 15, hold 37 cycles, `pause` again → resumes RUN; 00:00 is reached after exactly 50 RUN cycles. `start` during RUN causes no change.
- Simultaneous `clear`+`start` during RUN → IDLE, 00:00. `rst_n` low mid-count (asynchronous, between edges) → all outputs 0 immediately.
- DONE behaviour:
  - With the macro enabled and `ALARM_SECS`=2: `timeUp` falls 20 cycles after entry to DONE.
  - Without the macro: `timeUp` still high after 200 cycles, and `start` reloads the preset.
